// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down counter with modulus, step, load and wrap/saturate
module updown_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int STEP    = 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             WrapPulse,
  output logic             LoadErr
);

  localparam int WP1 = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_W  = WP1'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD_W  = WP1'(MODULUS);
  localparam logic [WIDTH:0] STEP_W = WP1'(STEP);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
        STEP < 1 || STEP >= MODULUS) begin : g_param_err
      $error("updown_counter_mod: illegal WIDTH/MODULUS/STEP combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   wrap_up;
  logic [WIDTH:0]   diff_dn;
  logic [WIDTH:0]   wrap_dn;

  // All arithmetic is done one bit wider so S = Count+STEP cannot overflow.
  assign cnt_ext = {1'b0, count_q};
  assign sum_up  = cnt_ext + STEP_W;
  assign wrap_up = sum_up - MOD_W;
  assign diff_dn = cnt_ext - STEP_W;
  assign wrap_dn = cnt_ext + MOD_W - STEP_W;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (Load) begin
      if ({1'b0, LoadVal} <= MAX_W) begin
        count_d = LoadVal;
      end else begin
        count_d = MAX_W[WIDTH-1:0];
        lerr_d  = 1'b1;
      end
    end else if (En) begin
      if (UpOrDown) begin
        if (sum_up <= MAX_W) begin
          count_d = sum_up[WIDTH-1:0];
        end else if (!Mode) begin
          count_d = wrap_up[WIDTH-1:0];
          wrap_d  = 1'b1;
        end else begin
          count_d = MAX_W[WIDTH-1:0];
        end
      end else begin
        if (cnt_ext >= STEP_W) begin
          count_d = diff_dn[WIDTH-1:0];
        end else if (!Mode) begin
          count_d = wrap_dn[WIDTH-1:0];
          wrap_d  = 1'b1;
        end else begin
          count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign Count     = count_q;
  assign WrapPulse = wrap_q;
  assign LoadErr   = lerr_q;
  assign Tc        = UpOrDown ? (count_q == MAX_W[WIDTH-1:0]) : (count_q == '0);

endmodule
